// File: rtl/rv_encode_pkg.sv
`default_nettype none
// ===========================================================================
// rv_encode_pkg : RV32I op codes, opcode/funct3 constants, immediate limits
// Rev 1.0
// ===========================================================================
package rv_encode_pkg;

   typedef enum logic [3:0] {
      OP_ADDI = 4'd0,
      OP_ORI  = 4'd1,
      OP_SLTI = 4'd2,
      OP_ANDI = 4'd3,
      OP_LW   = 4'd4,
      OP_SW   = 4'd5,
      OP_BEQ  = 4'd6,
      OP_BNE  = 4'd7,
      OP_BLT  = 4'd8,
      OP_BGE  = 4'd9,
      OP_BLTU = 4'd10,
      OP_BGEU = 4'd11,
      OP_JAL  = 4'd12
   } op_e;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_ORI  = 3'b110;
   localparam logic [2:0] F3_SLTI = 3'b010;
   localparam logic [2:0] F3_ANDI = 3'b111;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Signed immediate widths: I/S [-2048,2047], B [-4096,4094], J [-2^20,2^20-2]
   localparam int IMM_I_BITS = 12;
   localparam int IMM_B_BITS = 13;
   localparam int IMM_J_BITS = 21;

   function automatic logic [2:0] funct3_of(input logic [3:0] op);
      logic [2:0] f3;
      case (op)
         OP_ADDI: f3 = F3_ADDI;
         OP_ORI:  f3 = F3_ORI;
         OP_SLTI: f3 = F3_SLTI;
         OP_ANDI: f3 = F3_ANDI;
         OP_LW:   f3 = F3_LW;
         OP_SW:   f3 = F3_SW;
         OP_BEQ:  f3 = F3_BEQ;
         OP_BNE:  f3 = F3_BNE;
         OP_BLT:  f3 = F3_BLT;
         OP_BGE:  f3 = F3_BGE;
         OP_BLTU: f3 = F3_BLTU;
         OP_BGEU: f3 = F3_BGEU;
         default: f3 = 3'b000;
      endcase
      return f3;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
   endfunction

   // Bit 0 of B/J offsets is implied zero, so only [N:1] is passed in.
   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encode_core.sv
`default_nettype none
// ===========================================================================
// instr_encode_core : combinational RV32I word builder with legality check
// Rev 1.0
// ===========================================================================
module instr_encode_core
   import rv_encode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic [3:0]            op,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [DATA_WIDTH-1:0] imm,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  illegal
);

   logic [DATA_WIDTH-1:0] imm_sh_i;
   logic [DATA_WIDTH-1:0] imm_sh_b;
   logic [DATA_WIDTH-1:0] imm_sh_j;
   logic                  fits_i;
   logic                  fits_b;
   logic                  fits_j;
   logic [2:0]            f3;
   logic [31:0]           word;

   // A value fits N signed bits when everything from bit N-1 up is a pure sign copy.
   assign imm_sh_i = $signed(imm) >>> (IMM_I_BITS - 1);
   assign imm_sh_b = $signed(imm) >>> (IMM_B_BITS - 1);
   assign imm_sh_j = $signed(imm) >>> (IMM_J_BITS - 1);
   assign fits_i   = (imm_sh_i == '0) || (imm_sh_i == '1);
   assign fits_b   = ((imm_sh_b == '0) || (imm_sh_b == '1)) && !imm[0];
   assign fits_j   = ((imm_sh_j == '0) || (imm_sh_j == '1)) && !imm[0];
   assign f3       = funct3_of(op);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op)
         OP_ADDI, OP_ORI, OP_SLTI, OP_ANDI: begin
            word    = enc_i(imm[11:0], rs1, f3, rd, OPC_OPIMM);
            illegal = !fits_i;
         end
         OP_LW: begin
            word    = enc_i(imm[11:0], rs1, f3, rd, OPC_LOAD);
            illegal = !fits_i;
         end
         OP_SW: begin
            word    = enc_s(imm[11:0], rs2, rs1, f3);
            illegal = !fits_i;
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            word    = enc_b(imm[12:1], rs2, rs1, f3);
            illegal = !fits_b;
         end
         OP_JAL: begin
            word    = enc_j(imm[20:1], rd);
            illegal = !fits_j;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign instr = DATA_WIDTH'(word);

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ===========================================================================
// instr_encoder : streams descriptors into addressed RV32I instruction words
// Rev 1.0
// ===========================================================================
module instr_encoder
   import rv_encode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] base_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_addr,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           word_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]            state_q,      state_d;
   logic                  out_valid_q,  out_valid_d;
   logic [DATA_WIDTH-1:0] out_instr_q,  out_instr_d;
   logic [DATA_WIDTH-1:0] out_addr_q,   out_addr_d;
   logic [DATA_WIDTH-1:0] addr_q,       addr_d;
   logic                  done_q,       done_d;
   logic                  err_q,        err_d;
   logic [15:0]           word_count_q, word_count_d;

   logic [DATA_WIDTH-1:0] enc_instr;
   logic                  enc_illegal;
   logic                  accept;

   instr_encode_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .op      (in_op),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .instr   (enc_instr),
      .illegal (enc_illegal)
   );

   // Accept whenever the single output slot is empty or being emptied this cycle.
   assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_addr_d   = out_addr_q;
      addr_d       = addr_q;
      done_d       = 1'b0;
      err_d        = err_q;
      word_count_d = word_count_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               addr_d       = base_addr;
               word_count_d = '0;
               err_d        = 1'b0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (enc_illegal) begin
                  err_d = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_instr_d = enc_instr;
                  out_addr_d  = addr_q;
                  addr_d      = addr_q + DATA_WIDTH'(4);
                  if (word_count_q != 16'hFFFF) begin
                     word_count_d = word_count_q + 16'd1;
                  end
               end
               if (in_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!out_valid_q || out_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         out_valid_q  <= 1'b0;
         out_instr_q  <= '0;
         out_addr_q   <= '0;
         addr_q       <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_addr_q   <= out_addr_d;
         addr_q       <= addr_d;
         done_q       <= done_d;
         err_q        <= err_d;
         word_count_q <= word_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_instr  = out_instr_q;
   assign out_addr   = out_addr_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ===========================================================================
// tb_instr_encoder : directed vector table plus stall/drain/reset sequences
// Rev 1.0
// ===========================================================================
module tb_instr_encoder;
   import rv_encode_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] base_addr = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_op = '0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [DW-1:0] in_imm = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_instr;
   logic [DW-1:0] out_addr;
   logic          done;
   logic          err;
   logic [15:0]   word_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
      logic [31:0] instr;
   } vec_t;

   vec_t        vecs [16];
   logic [31:0] exp_addr;
   logic [15:0] exp_wc;
   logic [31:0] addr_a;

   instr_encoder #(
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
      in_last  = last;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{OP_ADDI, 5'd1,  5'd0, 5'd0, 32'd5,        1'b0, 32'h00500093};
      vecs[1]  = '{OP_SW,   5'd0,  5'd0, 5'd2, 32'd8,        1'b0, 32'h00202423};
      vecs[2]  = '{OP_BEQ,  5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3};
      vecs[3]  = '{OP_JAL,  5'd1,  5'd0, 5'd0, 32'd8,        1'b0, 32'h008000EF};
      vecs[4]  = '{OP_ORI,  5'd3,  5'd4, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF26193};
      vecs[5]  = '{OP_ANDI, 5'd5,  5'd6, 5'd7, 32'd2047,     1'b0, 32'h7FF37293};
      vecs[6]  = '{OP_ADDI, 5'd1,  5'd0, 5'd0, 32'd2048,     1'b1, 32'h0};
      vecs[7]  = '{OP_BEQ,  5'd0,  5'd1, 5'd2, 32'd3,        1'b1, 32'h0};
      vecs[8]  = '{OP_LW,   5'd10, 5'd2, 5'd0, 32'hFFFFF800, 1'b0, 32'h80012503};
      vecs[9]  = '{OP_BGEU, 5'd0,  5'd3, 5'd4, 32'd4094,     1'b0, 32'h7E41FFE3};
      vecs[10] = '{4'd13,   5'd1,  5'd1, 5'd1, 32'd0,        1'b1, 32'h0};
      vecs[11] = '{OP_JAL,  5'd0,  5'd0, 5'd0, 32'hFFF00000, 1'b0, 32'h8000006F};
      vecs[12] = '{OP_JAL,  5'd1,  5'd0, 5'd0, 32'h00100000, 1'b1, 32'h0};
      vecs[13] = '{OP_BLT,  5'd0,  5'd5, 5'd6, 32'hFFFFF000, 1'b0, 32'h8062C063};
      vecs[14] = '{OP_SW,   5'd0,  5'd1, 5'd2, 32'hFFFFF7FF, 1'b1, 32'h0};
      vecs[15] = '{OP_SLTI, 5'd1,  5'd1, 5'd0, 32'd0,        1'b0, 32'h0000A093};

      // Reset state
      #12;
      check("rst out_valid",  {31'd0, out_valid}, 32'd0);
      check("rst in_ready",   {31'd0, in_ready},  32'd0);
      check("rst done",       {31'd0, done},      32'd0);
      check("rst err",        {31'd0, err},       32'd0);
      check("rst word_count", {16'd0, word_count}, 32'd0);
      check("rst out_instr",  out_instr, 32'd0);
      check("rst out_addr",   out_addr,  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Program 1: table of descriptors, continuous flow
      start     = 1'b1;
      base_addr = 32'h100;
      tick();
      start    = 1'b0;
      exp_addr = 32'h100;
      exp_wc   = 16'd0;
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
         #1;
         check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
         tick();
         if (vecs[i].ill) begin
            check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("v%0d err", i),       {31'd0, err},       32'd1);
         end else begin
            check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d out_instr", i), out_instr, vecs[i].instr);
            check($sformatf("v%0d out_addr", i),  out_addr,  exp_addr);
            exp_addr = exp_addr + 32'd4;
            exp_wc   = exp_wc + 16'd1;
         end
      end
      check("table word_count", {16'd0, word_count}, {16'd0, exp_wc});

      // Stall: word A held while out_ready low, start ignored in RUN
      drive(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
      tick();
      addr_a   = exp_addr;
      exp_addr = exp_addr + 32'd4;
      exp_wc   = exp_wc + 16'd1;
      check("A out_instr", out_instr, 32'h00100113);
      out_ready = 1'b0;
      drive(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd2, 1'b0);
      start     = 1'b1;
      base_addr = 32'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("stall%0d in_ready", i),  {31'd0, in_ready},  32'd0);
         check($sformatf("stall%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("stall%0d out_instr", i), out_instr, 32'h00100113);
         check($sformatf("stall%0d out_addr", i),  out_addr,  addr_a);
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      #1;
      check("release in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("B out_instr", out_instr, 32'h00200193);
      check("B out_addr",  out_addr,  exp_addr);
      exp_addr = exp_addr + 32'd4;
      exp_wc   = exp_wc + 16'd1;

      // Last descriptor C with the consumer stalled, done after final handshake
      drive(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd3, 1'b1);
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      exp_wc    = exp_wc + 16'd1;
      check("C out_instr", out_instr, 32'h00300213);
      check("C out_addr",  out_addr,  exp_addr);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("drain%0d in_ready", i),  {31'd0, in_ready},  32'd0);
         check($sformatf("drain%0d done", i),      {31'd0, done},      32'd0);
         check($sformatf("drain%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("done pulse",      {31'd0, done},      32'd1);
      check("done out_valid",  {31'd0, out_valid}, 32'd0);
      check("done word_count", {16'd0, word_count}, {16'd0, exp_wc});
      tick();
      check("done cleared", {31'd0, done}, 32'd0);

      // IDLE ignores in_valid
      drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
      #1;
      check("idle in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      tick();
      check("idle out_valid",  {31'd0, out_valid}, 32'd0);
      check("idle done",       {31'd0, done},      32'd0);
      check("idle word_count", {16'd0, word_count}, {16'd0, exp_wc});
      in_valid = 1'b0;

      // Program 2: address wrap and err cleared by start, then reset mid-RUN
      start     = 1'b1;
      base_addr = 32'hFFFFFFFC;
      tick();
      start = 1'b0;
      check("p2 err",        {31'd0, err},        32'd0);
      check("p2 word_count", {16'd0, word_count}, 32'd0);
      drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      tick();
      check("p2 w0 addr", out_addr, 32'hFFFFFFFC);
      drive(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
      tick();
      check("p2 w1 addr",  out_addr,  32'h0);
      check("p2 w1 instr", out_instr, 32'h00100113);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst out_valid",  {31'd0, out_valid}, 32'd0);
      check("arst word_count", {16'd0, word_count}, 32'd0);
      check("arst in_ready",   {31'd0, in_ready},  32'd0);
      check("arst out_instr",  out_instr, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post-rst in_ready",  {31'd0, in_ready},  32'd0);
      tick();
      check("post-rst out_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
